trng_collect: RTL and testbench



---
 rtl/trng_collect.sv | 140 ++++++++++++++
 tb/tb_trng_collect.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collect.sv
// rtl/trng_collect.sv - von Neumann debiased TRNG word collector with repetition-count health test
// Pairs raw samples into debiased bits, shifts them into an N-bit word, aborts with res_err on long runs.
module trng_collect #(
  parameter int N   = 128,
  parameter int RCT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         raw_bit,
  input  logic         raw_valid,
  output logic [N-1:0] x_out,
  output logic         res_err,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [7:0]    RUN_CUT  = 8'(RCT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    x_q, x_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [7:0]      run_q, run_d;

  logic            emit;
  logic [7:0]      run_next;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    first_d  = first_q;
    last_d   = last_q;
    run_d    = run_q;
    emit     = 1'b0;
    run_next = run_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = COLLECT;
          cnt_d   = '0;
          phase_d = 1'b0;
          run_d   = '0;
          err_d   = 1'b0;
        end
      end

      COLLECT: begin
        if (raw_valid) begin
          // run_q == 0 means no sample seen yet in this collection
          if (run_q == 8'd0 || raw_bit != last_q) begin
            run_next = 8'd1;
          end else begin
            run_next = run_q + 8'd1;
          end
          run_d  = run_next;
          last_d = raw_bit;

          if (!phase_q) begin
            first_d = raw_bit;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            emit    = (first_q != raw_bit);
          end

          if (emit) begin
            x_d   = {x_q[N-2:0], first_q};
            cnt_d = cnt_q + CW'(1);
          end

          // Health-test failure wins over a word completing on the same sample
          if (run_next == RUN_CUT) begin
            state_d = DONE;
            err_d   = 1'b1;
            x_d     = '0;
          end else if (emit && cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      first_q <= first_d;
      last_q  <= last_d;
      run_q   <= run_d;
    end
  end

  assign x_out     = x_q;
  assign res_err   = err_q;
  assign req_ready = (state_q == IDLE);
  assign req_busy  = (state_q == COLLECT);
  assign res_valid = (state_q == DONE);

endmodule

// File: tb/tb_trng_collect.sv
// tb/tb_trng_collect.sv - randomized bench for trng_collect against a sample-list reference model
module tb_trng_collect;
  localparam int N   = 128;
  localparam int RCT = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         raw_bit = 1'b0;
  logic         raw_valid = 1'b0;
  logic         req_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [N-1:0] x_out;
  logic         res_err;
  logic         req_ready;
  logic         req_busy;
  logic         res_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: 0 = idle, 1 = collecting, 2 = result held
  int           m_st = 0;
  logic [N-1:0] m_x = '0;
  logic         m_err = 1'b0;
  bit           samples[$];

  trng_collect #(.N(N), .RCT(RCT)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .x_out     (x_out),
    .res_err   (res_err),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_busy  (req_busy),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int emitted_bits();
    int c = 0;
    for (int i = 0; i + 1 < samples.size(); i += 2)
      if (samples[i] != samples[i+1]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_x   = '0;
    m_err = 1'b0;
    samples.delete();
  endtask

  task automatic model_step(input bit rv, input bit rb, input bit rq, input bit rr);
    int n;
    int run;
    case (m_st)
      0: if (rq) begin
        m_st  = 1;
        m_err = 1'b0;
        samples.delete();
      end
      1: if (rv) begin
        samples.push_back(rb);
        n   = samples.size();
        run = 1;
        for (int i = n - 2; i >= 0; i--) begin
          if (samples[i] != rb) break;
          run++;
        end
        if (n % 2 == 0 && samples[n-2] != samples[n-1])
          m_x = {m_x[N-2:0], samples[n-2]};
        if (run >= RCT) begin
          m_st  = 2;
          m_err = 1'b1;
          m_x   = '0;
        end else if (emitted_bits() == N) begin
          m_st = 2;
        end
      end
      default: if (rr) m_st = 0;
    endcase
  endtask

  task automatic tick(input bit rv, input bit rb, input bit rq, input bit rr);
    raw_valid = rv;
    raw_bit   = rb;
    req_valid = rq;
    res_ready = rr;
    @(posedge clk);
    model_step(rv, rb, rq, rr);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, "_rst_req_ready"}, N'(req_ready), N'(1));
    check({tag, "_rst_req_busy"},  N'(req_busy),  N'(0));
    check({tag, "_rst_res_valid"}, N'(res_valid), N'(0));
    check({tag, "_rst_res_err"},   N'(res_err),   N'(0));
    check({tag, "_rst_x_out"},     x_out,         '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cmp_req_ready", N'(req_ready), N'(m_st == 0));
      check("cmp_req_busy",  N'(req_busy),  N'(m_st == 1));
      check("cmp_res_valid", N'(res_valid), N'(m_st == 2));
      check("cmp_res_err",   N'(res_err),   N'(m_err));
      check("cmp_x_out",     x_out,         m_x);
    end
  end

  initial begin
    logic [7:0] pat;
    bit         rv, rb, rq, rr;
    int         mode;

    raw_valid = 1'b0;
    raw_bit   = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    do_reset("init");
    chk_en = 1'b1;

    // Alternating 1,0 -> every pair emits a 1
    tick(0, 0, 1, 0);
    for (int i = 0; i < N; i++) begin
      tick(1, 1, 0, 0);
      if (i == N - 1) check("ones_before_last", N'(res_valid), N'(0));
      tick(1, 0, 0, 0);
    end
    check("ones_valid", N'(res_valid), N'(1));
    check("ones_err",   N'(res_err),   N'(0));
    check("ones_x",     x_out,         {N{1'b1}});
    tick(0, 0, 0, 1);
    check("ones_back_idle", N'(req_ready), N'(1));

    // 11 and 00 discarded, 01 -> 0, 10 -> 1
    pat = 8'b11010010;
    tick(0, 0, 1, 0);
    for (int r = 0; r < 64; r++) begin
      for (int j = 7; j >= 0; j--) tick(1, pat[j], 0, 0);
      if (r == 31) check("alt_half_busy", N'(req_busy), N'(1));
    end
    check("alt_valid", N'(res_valid), N'(1));
    check("alt_err",   N'(res_err),   N'(0));
    check("alt_x",     x_out,         {(N/2){2'b01}});
    tick(0, 0, 0, 1);

    // RCT consecutive zeros trip the health test
    tick(0, 0, 1, 0);
    for (int i = 0; i < RCT; i++) begin
      tick(1, 0, 0, 0);
      if (i == RCT - 2) check("rct_not_yet", N'(req_busy), N'(1));
    end
    check("rct_valid", N'(res_valid), N'(1));
    check("rct_err",   N'(res_err),   N'(1));
    check("rct_x",     x_out,         '0);
    tick(0, 0, 0, 1);

    // RCT-1 zeros then a one is not an error
    tick(0, 0, 1, 0);
    for (int i = 0; i < RCT - 1; i++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    check("rct_m1_busy", N'(req_busy), N'(1));
    check("rct_m1_err",  N'(res_err),  N'(0));
    for (int i = 0; i < 400 && m_st == 1; i++) begin
      tick(1, 1, 0, 0);
      tick(1, 0, 0, 0);
    end
    check("rct_m1_done", N'(res_valid), N'(1));
    check("rct_m1_err2", N'(res_err),   N'(0));

    // Result held while consumer stalls, raw and req inputs must not disturb it
    for (int i = 0; i < 1000; i++)
      tick(1'($urandom), 1'($urandom), 1'($urandom), 0);
    check("hold_valid", N'(res_valid), N'(1));
    tick(0, 0, 0, 1);
    check("hold_release", N'(req_ready), N'(1));

    // Reset after 100 emitted bits discards the partial word
    tick(0, 0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      tick(1, 1, 0, 0);
      tick(1, 0, 0, 0);
    end
    do_reset("mid");
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    for (int i = 0; i < N - 1; i++) begin
      tick(1, 0, 0, 0);
      tick(1, 1, 0, 0);
    end
    check("post_rst_busy", N'(req_busy), N'(1));
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    check("post_rst_valid", N'(res_valid), N'(1));
    check("post_rst_x",     x_out,         '0);

    // Ignored inputs: res_ready in idle, raw sample alongside the request
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("idle_res_ready", N'(req_ready), N'(1));
    tick(1, 1, 1, 1);
    tick(1, 0, 1, 0);
    tick(1, 1, 1, 0);
    check("req_in_collect", N'(req_busy), N'(1));

    // Randomized traffic with biased and unbiased sources
    mode = 0;
    for (int c = 0; c < 20000; c++) begin
      if (c % 2000 == 0) mode = $urandom_range(0, 3);
      if (c % 5000 == 2500) do_reset("rand");
      rv = ($urandom % 4) != 0;
      if (mode == 0) rb = ($urandom % 32) != 0;
      else           rb = 1'($urandom);
      rq = (m_st == 0) ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
      rr = (m_st == 2) ? ($urandom % 3 == 0) : ($urandom % 5 == 0);
      tick(rv, rb, rq, rr);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
